// File: rtl/fetch_stage_if.sv
// ============================================================================
//  fetch_stage_if : control, redirect, instruction-memory and IF/ID signals
//                   shared by the IF stage and its environment.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        pc_oor;

  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_target, imem_instr,
    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, pc_oor
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_target, imem_instr,
    input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, pc_oor
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  fetch_stage : MIPS IF stage - PC register, next-PC select, IF/ID register.
//  Optional macro FETCH_PERF_COUNT_EN adds fetch/stall/redirect counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_redirect_cnt
`endif
);

  // 33-bit so that IMEM_WORDS*4 == 2^32 still compares correctly
  localparam logic [32:0] C_IMEM_BYTES = 33'(IMEM_WORDS) << 2;
  localparam logic [31:0] C_RESET_PC   = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q,   pp4_d;
  logic        valid_q, valid_d;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    if (bus.jump) begin
      pc_d    = {bus.jump_target[31:2], 2'b00};
      instr_d = 32'd0;
      pp4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (bus.branch_taken) begin
      pc_d    = {bus.branch_target[31:2], 2'b00};
      instr_d = 32'd0;
      pp4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (bus.flush) begin
      instr_d = 32'd0;
      pp4_d   = 32'd0;
      valid_d = 1'b0;
      if (!bus.stall) pc_d = w_pc_plus4;
    end else if (!bus.stall) begin
      pc_d    = w_pc_plus4;
      instr_d = bus.imem_instr;
      pp4_d   = w_pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= C_RESET_PC;
      instr_q <= 32'd0;
      pp4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc_plus4 = pp4_q;
  assign bus.ifid_valid    = valid_q;
  // Advisory only: fetch proceeds regardless of the range check
  assign bus.pc_oor        = ({1'b0, pc_q} >= C_IMEM_BYTES);

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, redirect_cnt_q;
  logic        w_redirect, w_stall_case, w_fetch_case;

  assign w_redirect   = bus.jump | bus.branch_taken;
  assign w_stall_case = !w_redirect && !bus.flush &&  bus.stall;
  assign w_fetch_case = !w_redirect && !bus.flush && !bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= 32'd0;
      stall_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      if (w_fetch_case) fetch_cnt_q    <= fetch_cnt_q + 32'd1;
      if (w_stall_case) stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (w_redirect)   redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  tb_fetch_stage : directed vector table plus reset sequences for fetch_stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fetch_stage_if bus ();

  logic [31:0] mem [256];

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt;
  int          m_fetch, m_stall, m_redir;
`endif

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (256)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus.master)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  // Out-of-range reads return a recognisable address-tagged word
  assign bus.imem_instr = (bus.imem_addr < 32'h400) ? mem[bus.imem_addr[9:2]]
                                                    : (32'hBAD0_0000 | {16'h0, bus.imem_addr[15:0]});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        e_valid;
    logic        e_oor;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, input logic fl, input logic br,
                              input logic [31:0] brt, input logic jp, input logic [31:0] jt,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] pp4, input logic v, input logic oor);
    vec_t r;
    r.stall = st; r.flush = fl; r.br = br; r.brt = brt; r.jmp = jp; r.jt = jt;
    r.e_pc = pc; r.e_instr = ins; r.e_pp4 = pp4; r.e_valid = v; r.e_oor = oor;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] pp4, input logic v, input logic oor);
    chk({tag, ".pc"},    bus.imem_addr,            pc);
    chk({tag, ".instr"}, bus.ifid_instr,           ins);
    chk({tag, ".pp4"},   bus.ifid_pc_plus4,        pp4);
    chk({tag, ".valid"}, {31'd0, bus.ifid_valid},  {31'd0, v});
    chk({tag, ".oor"},   {31'd0, bus.pc_oor},      {31'd0, oor});
  endtask

  task automatic drive(input logic st, input logic fl, input logic br, input logic [31:0] brt,
                       input logic jp, input logic [31:0] jt);
    bus.stall = st; bus.flush = fl; bus.branch_taken = br;
    bus.branch_target = brt; bus.jump = jp; bus.jump_target = jt;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;

    //          st fl br brt            jp jt             pc             instr          pp4            v  oor
    vecs[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1, 0);
    vecs[2]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1, 0);
    vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 32'hA000_0001, 32'h0000_0008, 1, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_000C, 32'hA000_0002, 32'h0000_000C, 1, 0);
    vecs[5]  = mk(1, 0, 1, 32'h23,       0, 32'h0,        32'h0000_0020, 32'h0,         32'h0,         0, 0);
    vecs[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0024, 32'hA000_0008, 32'h0000_0024, 1, 0);
    vecs[7]  = mk(0, 0, 1, 32'h80,       1, 32'h40,       32'h0000_0040, 32'h0,         32'h0,         0, 0);
    vecs[8]  = mk(0, 0, 0, 32'h0,        1, 32'h0C,       32'h0000_000C, 32'h0,         32'h0,         0, 0);
    vecs[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 32'hA000_0003, 32'h0000_0010, 1, 0);
    vecs[10] = mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h0000_0014, 32'h0,         32'h0,         0, 0);
    vecs[11] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0018, 32'hA000_0005, 32'h0000_0018, 1, 0);
    vecs[12] = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h0000_0018, 32'h0,         32'h0,         0, 0);
    vecs[13] = mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0018, 32'h0,         32'h0,         0, 0);
    vecs[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_001C, 32'hA000_0006, 32'h0000_001C, 1, 0);
    vecs[15] = mk(0, 1, 1, 32'h31,       0, 32'h0,        32'h0000_0030, 32'h0,         32'h0,         0, 0);
    vecs[16] = mk(0, 0, 0, 32'h0,        1, 32'h3FC,      32'h0000_03FC, 32'h0,         32'h0,         0, 0);
    vecs[17] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0400, 32'hA000_00FF, 32'h0000_0400, 1, 1);
    vecs[18] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0404, 32'hBAD0_0400, 32'h0000_0404, 1, 1);
    vecs[19] = mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,        32'h0,         0, 1);
    vecs[20] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 32'hBAD0_FFFC, 32'h0000_0000, 1, 0);
    vecs[21] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 32'hA000_0000, 32'h0000_0004, 1, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 32'h0);
`ifdef FETCH_PERF_COUNT_EN
    m_fetch = 0; m_stall = 0; m_redir = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].brt, vecs[i].jmp, vecs[i].jt);
`ifdef FETCH_PERF_COUNT_EN
      if (vecs[i].jmp || vecs[i].br) m_redir++;
      else if (!vecs[i].flush && vecs[i].stall) m_stall++;
      else if (!vecs[i].flush) m_fetch++;
`endif
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4,
              vecs[i].e_valid, vecs[i].e_oor);
    end

`ifdef FETCH_PERF_COUNT_EN
    chk("perf_fetch",    perf_fetch_cnt,    32'(m_fetch));
    chk("perf_stall",    perf_stall_cnt,    32'(m_stall));
    chk("perf_redirect", perf_redirect_cnt, 32'(m_redir));
`endif

    // Asynchronous reset mid-cycle with a redirect pending
    drive(0, 0, 0, 32'h0, 1, 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_COUNT_EN
    chk("perf_rst", perf_fetch_cnt | perf_stall_cnt | perf_redirect_cnt, 32'h0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 32'h4, 32'hA000_0000, 32'h4, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
